// File: rtl/adder_ext_seq.sv
// adder_ext_seq: chunked multi-cycle add/sub/inc/dec with Start/Busy/Done handshake and registered Result, Cout, Overflow, Zero
module adder_ext_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [1:0]       Mode,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero
);
  localparam int N = WIDTH / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] x_q, y_q, sum_q, sum_d, y_map, result_q;
  logic [CHUNK:0] part;
  logic c_q, c0, last, accept, cout_q, ovf_q, zero_q;
  always_comb begin
    y_map = Mode == 2'b00 ? B : Mode == 2'b01 ? ~B : Mode == 2'b10 ? '0 : '1;
    c0 = Mode == 2'b00 ? Cin : Mode != 2'b11;
    accept = Start && state_q != BUSY;
    last = cnt_q == CW'(N - 1);
    part = {1'b0, x_q[cnt_q*CHUNK +: CHUNK]} + {1'b0, y_q[cnt_q*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c_q};
    sum_d = sum_q;
    sum_d[cnt_q*CHUNK +: CHUNK] = part[CHUNK-1:0];
    state_d = state_q == BUSY ? (last ? DONE : BUSY) : (accept ? BUSY : IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_q   <= A;
        y_q   <= y_map;
        c_q   <= c0;
        cnt_q <= '0;
      end else if (state_q == BUSY) begin
        sum_q <= sum_d;
        c_q   <= part[CHUNK];
        cnt_q <= last ? '0 : cnt_q + CW'(1);
        if (last) begin
          result_q <= sum_d;
          cout_q   <= part[CHUNK];
          ovf_q    <= x_q[WIDTH-1] == y_q[WIDTH-1] && sum_d[WIDTH-1] != x_q[WIDTH-1];
          zero_q   <= sum_d == '0;
        end
      end
    end
  end
  assign Busy = state_q == BUSY;
  assign Done = state_q == DONE;
  assign Result = result_q;
  assign Cout = cout_q;
  assign Overflow = ovf_q;
  assign Zero = zero_q;
endmodule

// File: tb/tb_adder_ext_seq.sv
// tb_adder_ext_seq: scoreboard bench over three parameterisations of adder_ext_seq
module tb_adder_ext_seq;
  localparam int WS [3] = '{32, 32, 16};
  localparam int CS [3] = '{8, 32, 4};
  localparam int NS [3] = '{4, 1, 4};
  typedef struct {
    logic [31:0] r;
    logic co, ov, z;
    int acc;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] st = '0, cin = '0, busy, done, co, ov, z;
  logic [1:0] mode [3];
  logic [31:0] a [3], b [3], res [3], hold [3];
  exp_t sbq [3][$];
  exp_t me;
  int errors = 0, checks = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  for (genvar i = 0; i < 3; i++) begin : g
    logic [WS[i]-1:0] r;
    adder_ext_seq #(.WIDTH(WS[i]), .CHUNK(CS[i])) u (
      .clk(clk), .rst_n(rst_n), .Start(st[i]), .A(a[i][WS[i]-1:0]), .B(b[i][WS[i]-1:0]),
      .Cin(cin[i]), .Mode(mode[i]), .Busy(busy[i]), .Done(done[i]), .Result(r),
      .Cout(co[i]), .Overflow(ov[i]), .Zero(z[i])
    );
    assign res[i] = 32'(r);
  end
  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at cycle %0d", nm, got, want, cyc);
    end
  endtask
  function automatic exp_t model(int k, logic [31:0] a_, logic [31:0] b_, logic ci, logic [1:0] m, int acc);
    int w = WS[k];
    longint unsigned mask, x, y, c, s;
    longint lim, sx, sy, ss;
    exp_t e;
    mask = (64'd1 << w) - 1;
    x = a_ & mask;
    y = m == 0 ? b_ & mask : m == 1 ? ~b_ & mask : m == 2 ? 0 : mask;
    c = m == 0 ? ci : m != 3;
    s = x + y + c;
    lim = longint'(64'd1 << (w - 1));
    sx = x >= lim ? longint'(x) - 2 * lim : longint'(x);
    sy = y >= lim ? longint'(y) - 2 * lim : longint'(y);
    ss = sx + sy + longint'(c);
    e.r = 32'(s & mask);
    e.co = s[w];
    e.ov = ss >= lim || ss < -lim;
    e.z = (s & mask) == 0;
    e.acc = acc;
    return e;
  endfunction
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (done[k]) begin
          if (sbq[k].size() == 0) chk($sformatf("spurious_done%0d", k), 1, 0);
          else begin
            me = sbq[k].pop_front();
            chk($sformatf("result%0d", k), res[k], me.r);
            chk($sformatf("cout%0d", k), co[k], me.co);
            chk($sformatf("overflow%0d", k), ov[k], me.ov);
            chk($sformatf("zero%0d", k), z[k], me.z);
            chk($sformatf("latency%0d", k), cyc - me.acc, NS[k]);
            hold[k] = me.r;
          end
        end else chk($sformatf("hold%0d", k), res[k], hold[k]);
      end
    end
  end
  task automatic wait_free(int k);
    @(negedge clk);
    for (int i = 0; i < 100 && busy[k]; i++) @(negedge clk);
    if (busy[k]) chk("wait_free_timeout", 1, 0);
  endtask
  task automatic issue(int k, logic [31:0] a_, logic [31:0] b_, logic ci, logic [1:0] m);
    wait_free(k);
    a[k] = a_; b[k] = b_; cin[k] = ci; mode[k] = m; st[k] = 1'b1;
    sbq[k].push_back(model(k, a_, b_, ci, m, cyc + 1));
    @(negedge clk);
    st[k] = 1'b0; a[k] = $urandom; b[k] = $urandom; cin[k] = 1'($urandom); mode[k] = 2'($urandom);
  endtask
  task automatic wait_idle(int k);
    for (int i = 0; i < 200 && sbq[k].size() != 0; i++) @(negedge clk);
    chk($sformatf("drain%0d", k), sbq[k].size(), 0);
  endtask
  function automatic logic [31:0] pick();
    int r = $urandom_range(0, 7);
    return r == 0 ? 32'h0 : r == 1 ? 32'hFFFFFFFF : r == 2 ? 32'h80000000 : r == 3 ? 32'h7FFFFFFF : $urandom;
  endfunction
  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int n;
    for (int k = 0; k < 3; k++) begin
      a[k] = '0; b[k] = '0; mode[k] = '0; hold[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_busy%0d", k), busy[k], 0);
      chk($sformatf("reset_done%0d", k), done[k], 0);
      chk($sformatf("reset_result%0d", k), res[k], 0);
      chk($sformatf("reset_flags%0d", k), {co[k], ov[k], z[k]}, 0);
    end
    rst_n = 1'b1;
    issue(0, 32'h10, 32'h20, 1'b0, 2'b00);
    n = 0;
    while (busy[0] && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, 4);
    chk("done_after_busy", done[0], 1);
    wait_idle(0);
    issue(0, 32'hFF, 32'h1, 1'b0, 2'b00);
    issue(0, 32'hFFFFFFFF, 32'h0, 1'b1, 2'b00);
    issue(0, 32'h20, 32'h10, 1'b0, 2'b01);
    issue(0, 32'h10, 32'h20, 1'b0, 2'b01);
    issue(0, 32'h7FFFFFFF, 32'h12345678, 1'b1, 2'b10);
    issue(0, 32'h0, 32'h9ABCDEF0, 1'b1, 2'b11);
    issue(0, 32'h0, 32'h80000000, 1'b0, 2'b01);
    wait_idle(0);
    issue(0, 32'h55, 32'h66, 1'b0, 2'b00);
    @(negedge clk);
    a[0] = 32'hDEAD; b[0] = 32'hBEEF; mode[0] = 2'b01; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    wait_idle(0);
    wait_free(0);
    a[0] = 32'h1234; b[0] = 32'h4321; cin[0] = 1'b1; mode[0] = 2'b00; st[0] = 1'b1;
    sbq[0].push_back(model(0, 32'h1234, 32'h4321, 1'b1, 2'b00, cyc + 1));
    @(negedge clk);
    a[0] = 32'h100; b[0] = 32'h300; cin[0] = 1'b0; mode[0] = 2'b01;
    n = 0;
    while (!done[0] && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_first_done", done[0], 1);
    sbq[0].push_back(model(0, 32'h100, 32'h300, 1'b0, 2'b01, cyc + 1));
    @(negedge clk);
    st[0] = 1'b0;
    wait_idle(0);
    issue(0, 32'h01020304, 32'h10, 1'b0, 2'b00);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      sbq[k].delete();
      hold[k] = '0;
    end
    @(negedge clk);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_done", done[0], 0);
    chk("midrst_result", res[0], 0);
    chk("midrst_flags", {co[0], ov[0], z[0]}, 0);
    rst_n = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (done[0]) n++;
    end
    chk("midrst_no_done", n, 0);
    for (int k = 0; k < 3; k++) begin
      repeat (80) issue(k, pick(), pick(), 1'($urandom), 2'($urandom_range(0, 3)));
      wait_idle(k);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder_ext_seq.md
Name: adder_ext_seq

Overview:
- Parametrised, multi-cycle successor to the 32-bit extended adder.
- Computes add, subtract, increment or decrement on WIDTH-bit operands, CHUNK bits per clock, carry rippling through a registered carry flop between chunks.
- Start/Busy/Done handshake; registered Result with Cout, signed Overflow and Zero flags.
- Sits in the datapath wherever a narrow, area-cheap adder with mode select is needed.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits processed per clock; N = WIDTH/CHUNK chunk cycles per operation; CHUNK = WIDTH gives N = 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous and active-low.
- Start  input  1  request; sampled only when Busy = 0.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- Cin  input  1  carry-in; used in Mode 00 only.
- Mode  input  2  00 add, 01 subtract, 10 increment, 11 decrement; captured on the accepting edge.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse: Result and flags are valid.
- Result  output  WIDTH  final result; holds until the next completion.
- Cout  output  1  carry out of the MSB.
- Overflow  output  1  signed two's-complement overflow.
- Zero  output  1  1 when Result == 0.

Behaviour:
- Reset: rst_n = 0 at an edge forces state IDLE, chunk counter 0, carry flop 0, and Busy, Done, Result, Cout, Overflow, Zero all 0.
- Reset mid-operation aborts it; no Done is produced. rst_n overrides Start on the same edge.
- Operand mapping after capture:
  - Mode 00: X = A, Y = B, c0 = Cin.
  - Mode 01: X = A, Y = ~B, c0 = 1. Cout = 1 means no borrow (A >= B unsigned).
  - Mode 10: X = A, Y = 0, c0 = 1.
  - Mode 11: X = A, Y = all-ones, c0 = 0. Cout = 0 only when A = 0.
- FSM states:
  - IDLE: Busy = 0. Start = 1 at an edge captures X, Y, the carry flop (c0) and Mode, and moves to BUSY with counter 0.
  - BUSY: Busy = 1. Each edge adds chunk[counter] of X and Y plus the carry flop into an internal shadow register, updates the carry flop, and increments the counter. The edge that processes chunk N-1 moves to DONE.
  - DONE: Busy = 0, Done = 1 for exactly one cycle. Result, Cout, Overflow and Zero load on the edge entering DONE. Next edge: Start = 1 captures a new operation and goes to BUSY (back-to-back); otherwise go to IDLE.
- Latency: with Start accepted at edge k, Busy is high after edges k .. k+N-1 and Done is high after edge k+N. Throughput is one operation per N+1 cycles.
- Start while Busy = 1 is ignored; it is not queued and captured operands are unaffected.
- Result and flags never show partial sums. They change only on entry to DONE or on reset.
- Overflow = (X[MSB] == Y[MSB]) && (sum[MSB] != X[MSB]), using the mapped Y. This is correct signed overflow for all four modes, including 0 - 0x80000000.
- Wrap-around is modulo 2^WIDTH; the carry out of the MSB goes to Cout only.
- A, B, Cin and Mode may change freely after capture without affecting the operation.

Test Plan:
(WIDTH = 32, CHUNK = 8, N = 4 unless stated)
- Add: A = 0x00000010, B = 0x00000020, Mode 00, Cin = 0, one-cycle Start -> Done 4 cycles after the accepting edge; Result 0x00000030; Cout 0; Overflow 0; Zero 0; Busy high for exactly 4 cycles.
- Inter-chunk carry and wrap:
  - 0x000000FF + 0x00000001 -> 0x00000100, Cout 0.
  - 0xFFFFFFFF + 0x00000000 with Cin = 1 -> 0x00000000, Cout 1, Zero 1.
- Sub, inc, dec:
  - Mode 01, 0x20 - 0x10 -> 0x00000010, Cout 1.
  - Mode 01, 0x10 - 0x20 -> 0xFFFFFFF0, Cout 0.
  - Mode 10, A = 0x7FFFFFFF -> 0x80000000, Overflow 1.
  - Mode 11, A = 0 -> 0xFFFFFFFF, Cout 0, Overflow 0.
- Handshake:
  - Start re-pulsed with new operands at cycle 2 of BUSY -> ignored; original result delivered.
  - Start held high through the DONE cycle -> second operation accepted; its Done arrives 5 cycles after the first Done.
  - Result stays stable between the two Done pulses.
- Reset mid-op: rst_n = 0 for one edge at cycle 2 of BUSY -> next cycle Busy 0, Done 0, Result 0 and all flags 0; no Done appears afterwards.
- Parameter sweep: CHUNK = 32 (N = 1) and WIDTH = 16, CHUNK = 4 -> random operands and modes match a reference model (Result, Cout, Overflow, Zero); Done latency equals N.
